// File: rtl/traffic_pkg.sv
// Shared lamp codes and sequencer state encoding for the intersection controller.
package traffic_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_1   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_2   = 3'd5
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clock divider producing a one-cycle tick every TICK_DIV clocks.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] pre_q, pre_d;
  logic          wrap;

  assign wrap = (pre_q == PW'(TICK_DIV - 1));

  always_comb begin
    pre_d = wrap ? '0 : pre_q + PW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pre_q <= '0;
    else          pre_q <= pre_d;
  end

  // Gated by reset so a divide-by-1 prescaler stays quiet while held in reset.
  assign tick = wrap & reset_n;

endmodule

// File: rtl/traffic_light_controller.sv
// Two-road intersection sequencer: main rests green, side requests and emergency
// preemption run timed yellow / all-red / side-green phases.
module traffic_light_controller
  import traffic_pkg::*;
#(
  parameter int TICK_DIV        = 50_000_000,
  parameter int MAIN_GREEN_MIN  = 10,
  parameter int YELLOW_TIME     = 3,
  parameter int ALL_RED_TIME    = 1,
  parameter int SIDE_GREEN_TIME = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       side_sensor,
  input  logic       emergency,
  output logic [1:0] main_light,
  output logic [1:0] side_light,
  output logic [2:0] state_o,
  output logic       tick_o
);

  localparam int MAXD = max2(max2(MAIN_GREEN_MIN, YELLOW_TIME),
                             max2(ALL_RED_TIME, SIDE_GREEN_TIME));
  // cnt only has to reach D-1 for the longest phase before saturating.
  localparam int CW   = (MAXD > 1) ? $clog2(MAXD) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            side_req_q, side_req_d;
  logic            tick;
  logic            done_mg, done_y, done_ar, done_sg;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  assign done_mg = tick && (cnt_q >= CW'(MAIN_GREEN_MIN - 1));
  assign done_y  = tick && (cnt_q >= CW'(YELLOW_TIME - 1));
  assign done_ar = tick && (cnt_q >= CW'(ALL_RED_TIME - 1));
  assign done_sg = tick && (cnt_q >= CW'(SIDE_GREEN_TIME - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ALL_RED_2;
      cnt_q      <= '0;
      side_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      side_req_q <= side_req_d;
    end
  end

  // Emergency forces greens to yellow immediately and pins all-red phases.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MAIN_GREEN:  if (emergency || (done_mg && side_req_q)) state_d = MAIN_YELLOW;
      MAIN_YELLOW: if (done_y)                               state_d = ALL_RED_1;
      ALL_RED_1:   if (done_ar && !emergency)                state_d = SIDE_GREEN;
      SIDE_GREEN:  if (emergency || done_sg)                 state_d = SIDE_YELLOW;
      SIDE_YELLOW: if (done_y)                               state_d = ALL_RED_2;
      ALL_RED_2:   if (done_ar && !emergency)                state_d = MAIN_GREEN;
      default:                                               state_d = ALL_RED_2;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)     cnt_d = '0;
    else if (tick && cnt_q != '1) cnt_d = cnt_q + CW'(1);
  end

  always_comb begin
    side_req_d = side_req_q;
    if (state_q != SIDE_GREEN && state_d == SIDE_GREEN) side_req_d = 1'b0;
    else if (side_sensor && state_q != SIDE_GREEN)      side_req_d = 1'b1;
  end

  always_comb begin
    main_light = LIGHT_RED;
    side_light = LIGHT_RED;
    case (state_q)
      MAIN_GREEN:  main_light = LIGHT_GREEN;
      MAIN_YELLOW: main_light = LIGHT_YELLOW;
      SIDE_GREEN:  side_light = LIGHT_GREEN;
      SIDE_YELLOW: side_light = LIGHT_YELLOW;
      default: ;
    endcase
  end

  assign state_o = state_q;
  assign tick_o  = tick;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench: TICK_DIV=1 instance for sequencing, TICK_DIV=4 instance for tick phase.
module tb_traffic_light_controller;

  logic       clk = 1'b0;
  logic       rst_n, sens, emer;
  logic       rst4_n, sens4, emer4;
  logic [1:0] m, s, m4, s4;
  logic [2:0] st, st4;
  logic       tk, tk4;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  traffic_light_controller #(
    .TICK_DIV(1), .MAIN_GREEN_MIN(4), .YELLOW_TIME(2), .ALL_RED_TIME(1), .SIDE_GREEN_TIME(3)
  ) dut (
    .clk(clk), .reset_n(rst_n), .side_sensor(sens), .emergency(emer),
    .main_light(m), .side_light(s), .state_o(st), .tick_o(tk)
  );

  traffic_light_controller #(
    .TICK_DIV(4), .MAIN_GREEN_MIN(4), .YELLOW_TIME(2), .ALL_RED_TIME(1), .SIDE_GREEN_TIME(3)
  ) dut4 (
    .clk(clk), .reset_n(rst4_n), .side_sensor(sens4), .emergency(emer4),
    .main_light(m4), .side_light(s4), .state_o(st4), .tick_o(tk4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_main(input int sc);
    return (sc == 0) ? 2'b01 : (sc == 1) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [1:0] exp_side(input int sc);
    return (sc == 3) ? 2'b01 : (sc == 4) ? 2'b10 : 2'b00;
  endfunction

  task automatic chk_st(input string tag, input int sc);
    chk({tag, "_state"}, 32'(st), 32'(sc));
    chk({tag, "_main"},  32'(m),  32'(exp_main(sc)));
    chk({tag, "_side"},  32'(s),  32'(exp_side(sc)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int svc[13];
    int pre[5];
    int emg[6];
    int post[8];
    svc  = '{0, 0, 0, 1, 1, 2, 3, 3, 3, 4, 4, 5, 0};
    pre  = '{0, 1, 1, 2, 3};
    emg  = '{4, 4, 5, 5, 5, 5};
    post = '{0, 0, 0, 0, 1, 1, 2, 3};
    rst_n = 1'b0; sens = 1'b0; emer = 1'b0;
    rst4_n = 1'b0; sens4 = 1'b0; emer4 = 1'b0;

    repeat (3) step();
    chk_st("reset", 5);
    chk("reset_tick", 32'(tk), 0);

    rst_n = 1'b1;
    step();
    chk_st("release", 0);

    // One-cycle sensor pulse at MAIN_GREEN cnt=0, full service cycle.
    sens = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step();
      sens = 1'b0;
      chk_st($sformatf("svc%0d", i), svc[i]);
    end

    for (int i = 0; i < 100; i++) begin
      step();
      chk_st($sformatf("idle%0d", i), 0);
    end

    // Pulse from saturated MAIN_GREEN: served on the next tick.
    sens = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      sens = 1'b0;
      chk_st($sformatf("pre%0d", i), pre[i]);
    end

    // Emergency at SIDE_GREEN cnt=0 for 6 cycles, sensor also active.
    emer = 1'b1; sens = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_st($sformatf("emg%0d", i), emg[i]);
    end
    emer = 1'b0; sens = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_st($sformatf("post%0d", i), post[i]);
    end

    // Asynchronous reset between edges while in SIDE_GREEN.
    #2 rst_n = 1'b0;
    #1 chk_st("async_rst", 5);
    step(); step();
    rst_n = 1'b1;
    step();
    chk_st("rst_restart", 0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk_st($sformatf("no_stale%0d", i), 0);
    end

    // TICK_DIV=4: tick phase and 16-clock MAIN_GREEN with pending request.
    chk("div4_rst_tick", 32'(tk4), 0);
    rst4_n = 1'b1; sens4 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      sens4 = 1'b0;
      chk($sformatf("div4_tick%0d", k), 32'(tk4), (k % 4 == 3) ? 1 : 0);
      chk($sformatf("div4_state%0d", k), 32'(st4), (k < 4) ? 5 : (k < 20) ? 0 : 1);
    end
    chk("div4_main_yel", 32'(m4), 2);
    chk("div4_side_red", 32'(s4), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
